// File: rtl/carbon_arch_pkg.sv
// rtl/carbon_arch_pkg.sv - shared FSM state type and constants for the fabric memory arbiter.
package carbon_arch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic        FAULT_OOR = 1'b1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: one-hot grant starting after the last served channel.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic [N-1:0] served,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_ptr;
  logic [PW-1:0] idx;
  int            s;

  // Scan from the farthest offset back to the pointer so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    s     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      idx = PW'(s);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_ptr = ptr;
    for (int i = 0; i < N; i++) begin
      if (served[i]) nxt_ptr = (i == N - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ptr <= '0;
    else if (en) ptr <= nxt_ptr;
  end

endmodule

// File: rtl/fabric_mem_arb_ram.sv
// rtl/fabric_mem_arb_ram.sv - multi-channel arbitrated RAM; FABRIC_MEM_STALL_INJECT_EN adds LFSR wait stretching.
module fabric_mem_arb_ram
  import carbon_arch_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_valid,
  input  logic [NUM_CH-1:0]        rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_fault
);

  localparam int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MEM_AW = $clog2(MEM_WORDS);

  state_t              state, next_state;
  logic [3:0]          cnt;
  logic [3:0]          wait_load;
  logic [PW-1:0]       ch_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                fault_q;
  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   served;
  logic [PW-1:0]       sel;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;
  logic                in_range;
  logic                accept;
  logic                rsp_done;

  logic [DATA_W-1:0]   mem [MEM_WORDS];

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (rsp_done),
    .served (served),
    .grant  (grant)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel = PW'(i);
    end
  end

  assign sel_addr  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(sel)*DATA_W +: DATA_W];
  assign sel_write = req_write[sel];
  assign in_range  = {1'b0, sel_addr} < (ADDR_W + 1)'(MEM_WORDS);
  assign accept    = (state == ST_IDLE) && !rst && (|grant);
  assign rsp_done  = (state == ST_RESP) && rsp_ready[ch_q];

`ifdef FABRIC_MEM_STALL_INJECT_EN
  logic [15:0] lfsr;
  logic [4:0]  wait_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lfsr <= LFSR_SEED;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Saturate so LATENCY=15 plus stall still fits the 4-bit counter.
  assign wait_sum  = 5'(LATENCY) + {3'b000, lfsr[1:0]};
  assign wait_load = wait_sum[4] ? 4'hF : wait_sum[3:0];
`else
  assign wait_load = 4'(LATENCY);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = (wait_load != 4'd0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt <= 4'd1) next_state = ST_RESP;
      ST_RESP: if (rsp_done) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_fault = 1'b0;
    served    = '0;
    if (state == ST_IDLE && !rst) req_ready = grant;
    if (state == ST_RESP) begin
      rsp_valid[ch_q] = 1'b1;
      rsp_rdata       = rdata_q;
      rsp_fault       = fault_q;
      served[ch_q]    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      ch_q    <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      cnt     <= wait_load;
      ch_q    <= sel;
      rdata_q <= (in_range && !sel_write) ? mem[sel_addr[MEM_AW-1:0]] : '0;
      fault_q <= in_range ? 1'b0 : FAULT_OOR;
    end else if (state == ST_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Backing store is never reset so writes survive a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (accept && sel_write && in_range) mem[sel_addr[MEM_AW-1:0]] <= sel_wdata;
  end

endmodule

// File: tb/tb_fabric_mem_arb_ram.sv
// tb/tb_fabric_mem_arb_ram.sv - directed self-checking bench for fabric_mem_arb_ram (LATENCY 1 and 0).
module tb_fabric_mem_arb_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_rdata;
  logic        rsp_fault;
  logic [1:0]  req_valid_z, req_ready_z, req_write_z, rsp_valid_z, rsp_ready_z;
  logic [31:0] req_addr_z;
  logic [15:0] req_wdata_z;
  logic [7:0]  rsp_rdata_z;
  logic        rsp_fault_z;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fabric_mem_arb_ram #(.NUM_CH(2), .ADDR_W(16), .DATA_W(8), .MEM_WORDS(4096), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  fabric_mem_arb_ram #(.NUM_CH(2), .ADDR_W(16), .DATA_W(8), .MEM_WORDS(4096), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_fault(rsp_fault_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic wr, input logic [15:0] addr, input logic [7:0] wd);
    req_write[ch]          = wr;
    req_addr[ch*16 +: 16]  = addr;
    req_wdata[ch*8 +: 8]   = wd;
  endtask

  // One full LATENCY=1 transaction on a single channel with the response accepted at once.
  task automatic do_txn(input string tag, input int ch, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_flt);
    drive(ch, wr, addr, wd);
    req_valid = 2'b01 << ch;
    #1;
    chk({tag, "_ready"}, req_ready, 2'b01 << ch);
    step();
    req_valid = 2'b00;
    chk({tag, "_wait"}, rsp_valid, 2'b00);
    step();
    chk({tag, "_valid"}, rsp_valid, 2'b01 << ch);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_fault"}, rsp_fault, exp_flt);
    rsp_ready = 2'b01 << ch;
    step();
    rsp_ready = 2'b00;
    chk({tag, "_done"}, rsp_valid, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 2'b11; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    req_valid_z = '0; req_write_z = '0; req_addr_z = '0; req_wdata_z = '0; rsp_ready_z = '0;
    step();
    step();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_fault", rsp_fault, 1'b0);
    chk("rst_rsp_valid_z", rsp_valid_z, 2'b00);
    req_valid = 2'b00;
    rst = 1'b0;

    do_txn("wr5a", 0, 1'b1, 16'h0010, 8'h5A, 8'h00, 1'b0);
    chk("mem_0010", u1.mem[12'h010], 8'h5A);
    do_txn("rd5a", 0, 1'b0, 16'h0010, 8'h00, 8'h5A, 1'b0);
    do_txn("wr_c3", 0, 1'b1, 16'h0000, 8'hC3, 8'h00, 1'b0);
    do_txn("wr_oor", 1, 1'b1, 16'h1000, 8'hFF, 8'h00, 1'b1);
    chk("mem_0000_kept", u1.mem[12'h000], 8'hC3);
    do_txn("rd_oor", 0, 1'b0, 16'h1000, 8'h00, 8'h00, 1'b1);
    do_txn("wr_top", 1, 1'b1, 16'h0FFF, 8'h9E, 8'h00, 1'b0);
    do_txn("rd_top", 1, 1'b0, 16'h0FFF, 8'h00, 8'h9E, 1'b0);

    // Fresh pointer, both channels hammering with responses always accepted.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1'b0, 16'h0010, 8'h00);
    drive(1, 1'b0, 16'h0FFF, 8'h00);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 8) begin
        step();
        n++;
      end
      chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    req_valid = 2'b00;
    step(); step(); step();

    // Response back-pressure on ch0 while ch1 waits.
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1;
    chk("hold_grant", req_ready, 2'b01);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", rsp_valid, 2'b01);
      chk("hold_rdata", rsp_rdata, 8'h5A);
      chk("hold_fault", rsp_fault, 1'b0);
      chk("hold_ch1_stall", req_ready, 2'b00);
      step();
    end
    rsp_ready = 2'b01;
    step();
    chk("hold_next_ch1", req_ready, 2'b10);
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Reset while waiting on an accepted write.
    drive(1, 1'b1, 16'h0020, 8'h33);
    req_valid = 2'b10;
    #1;
    chk("rstw_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    #1;
    rst = 1'b1;
    #1;
    chk("rstw_rsp_valid", rsp_valid, 2'b00);
    chk("rstw_rdata", rsp_rdata, 8'h00);
    chk("rstw_fault", rsp_fault, 1'b0);
    chk("rstw_mem", u1.mem[12'h020], 8'h33);
    step();
    rst = 1'b0;
    step();
    chk("rstw_no_rsp", rsp_valid, 2'b00);
    req_valid = 2'b11;
    #1;
    chk("rstw_next_ch0", req_ready, 2'b01);
    req_valid = 2'b00;

    // Zero-latency instance.
    req_write_z[0] = 1'b1; req_addr_z[15:0] = 16'h0005; req_wdata_z[7:0] = 8'h77;
    req_valid_z = 2'b01;
    #1;
    chk("l0_ready", req_ready_z, 2'b01);
    step();
    req_valid_z = 2'b00;
    chk("l0_wr_valid", rsp_valid_z, 2'b01);
    chk("l0_wr_rdata", rsp_rdata_z, 8'h00);
    chk("l0_wr_fault", rsp_fault_z, 1'b0);
    rsp_ready_z = 2'b01;
    step();
    rsp_ready_z = 2'b00;
    chk("l0_wr_done", rsp_valid_z, 2'b00);
    req_write_z[0] = 1'b0;
    req_valid_z = 2'b01;
    #1;
    chk("l0_rd_ready", req_ready_z, 2'b01);
    step();
    req_valid_z = 2'b00;
    chk("l0_rd_valid", rsp_valid_z, 2'b01);
    chk("l0_rd_rdata", rsp_rdata_z, 8'h77);
    rsp_ready_z = 2'b01;
    step();
    rsp_ready_z = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
